// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit. It has a registered state, combinational control
// decode, memory-ready stalls, a sticky illegal-opcode flag and a retired-instruction counter.

module mc_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ICNT_W        = 16,
  parameter bit ILLEGAL_HALT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        Op,
  input  logic [5:0]        Funct,
  input  logic              Zero,
  input  logic              Mem_Ready,
  output logic              PC_En,
  output logic              I_or_D,
  output logic              Mem_Write,
  output logic              IR_Write,
  output logic              Reg_Dst,
  output logic              Mem_to_Reg,
  output logic              Reg_Write,
  output logic              ALU_Src_A,
  output logic [1:0]        ALU_Src_B,
  output logic [2:0]        ALU_Control,
  output logic [1:0]        PC_Src,
  output logic              Illegal_Op,
  output logic [ICNT_W-1:0] Instr_Count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, EXEC_IZ, WB_I,
    MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ILLEGAL, HALT
  } state_t;

  state_t     state;
  logic       mem_ok;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       retire;
  logic       pc_write;
  logic       branch;
  logic       is_bne;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  // Without the handshake every memory access completes in its first cycle.
  assign mem_ok = MEM_HANDSHAKE ? Mem_Ready : 1'b1;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Control decode. The write enables are gated with reset so that an
  // abandoned instruction never commits anything.
  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    is_bne        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    I_or_D        = 1'b0;
    Reg_Dst       = 1'b0;
    Mem_to_Reg    = 1'b0;
    ALU_Src_A     = 1'b0;
    ALU_Src_B     = 2'b00;
    ALU_Control   = ALU_ADD;
    PC_Src        = 2'b00;
    case (state)
      FETCH: begin
        ALU_Src_B    = 2'b01;
        ir_write_raw = mem_ok;
        pc_write     = mem_ok;
      end
      DECODE: ALU_Src_B = 2'b10;
      EXEC_R: begin
        ALU_Src_A   = 1'b1;
        ALU_Control = funct_alu;
      end
      WB_R: begin
        Reg_Dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      EXEC_I, MEM_ADR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
      end
      EXEC_IZ: begin
        ALU_Src_A   = 1'b1;
        ALU_Src_B   = 2'b11;
        ALU_Control = (Op == OP_ORI) ? ALU_OR : ALU_AND;
      end
      WB_I: reg_write_raw = 1'b1;
      MEM_RD: I_or_D = 1'b1;
      MEM_WB: begin
        Mem_to_Reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEM_WR: begin
        I_or_D        = 1'b1;
        mem_write_raw = 1'b1;
      end
      BRANCH: begin
        ALU_Src_A   = 1'b1;
        ALU_Control = ALU_SUB;
        PC_Src      = 2'b01;
        branch      = 1'b1;
        is_bne      = (Op == OP_BNE);
      end
      JUMP: begin
        PC_Src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    PC_En     = ~reset & (pc_write | (branch & (Zero ^ is_bne)));
    Mem_Write = ~reset & mem_write_raw;
    IR_Write  = ~reset & ir_write_raw;
    Reg_Write = ~reset & reg_write_raw;
  end

  always_comb begin
    case (state)
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: retire = 1'b1;
      MEM_WR:                           retire = mem_ok;
      default:                          retire = 1'b0;
    endcase
  end

  // State sequencing, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      Illegal_Op  <= 1'b0;
      Instr_Count <= '0;
    end else begin
      if (retire)
        Instr_Count <= Instr_Count + ICNT_W'(1);
      case (state)
        FETCH: if (mem_ok) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_RTYPE:        state <= EXEC_R;
            OP_LW, OP_SW:    state <= MEM_ADR;
            OP_BEQ, OP_BNE:  state <= BRANCH;
            OP_J:            state <= JUMP;
            OP_ADDI:         state <= EXEC_I;
            OP_ANDI, OP_ORI: state <= EXEC_IZ;
            default:         state <= ILLEGAL;
          endcase
        end
        EXEC_R:          state <= funct_ok ? WB_R : ILLEGAL;
        EXEC_I, EXEC_IZ: state <= WB_I;
        MEM_ADR:         state <= (Op == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:          if (mem_ok) state <= MEM_WB;
        MEM_WR:          if (mem_ok) state <= FETCH;
        ILLEGAL: begin
          Illegal_Op <= 1'b1;
          state      <= ILLEGAL_HALT ? HALT : FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Two instances with different parameters share the stimulus.
// A per-instruction step model checks both of them every cycle, and directed literals pin the model.

module tb_mc_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam int S_FETCH = 0, S_DEC = 1, S_EXEC = 2, S_WB = 3, S_MWB = 4, S_ILL = 5, S_HALT = 6;
  localparam int C_R = 0, C_MEM = 1, C_BR = 2, C_J = 3, C_I = 4, C_IZ = 5;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  logic a_pc_en, a_i_or_d, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write, a_src_a;
  logic [1:0] a_src_b, a_pc_src;
  logic [2:0] a_alu;
  logic       a_ill;
  logic [1:0] a_cnt;
  logic b_pc_en, b_i_or_d, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_src_a;
  logic [1:0]  b_src_b, b_pc_src;
  logic [2:0]  b_alu;
  logic        b_ill;
  logic [15:0] b_cnt;

  int pass_count = 0;
  int check_count = 0;

  int          m_step [2] = '{S_FETCH, S_FETCH};
  int          m_cls  [2] = '{C_R, C_R};
  bit          m_store[2] = '{1'b0, 1'b0};
  bit          m_ill  [2] = '{1'b0, 1'b0};
  int unsigned m_cnt  [2] = '{0, 0};
  ctrl_t       act_w, exp_w;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .ICNT_W(2), .ILLEGAL_HALT(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero), .Mem_Ready(mem_ready),
    .PC_En(a_pc_en), .I_or_D(a_i_or_d), .Mem_Write(a_mem_write), .IR_Write(a_ir_write),
    .Reg_Dst(a_reg_dst), .Mem_to_Reg(a_mem_to_reg), .Reg_Write(a_reg_write),
    .ALU_Src_A(a_src_a), .ALU_Src_B(a_src_b), .ALU_Control(a_alu), .PC_Src(a_pc_src),
    .Illegal_Op(a_ill), .Instr_Count(a_cnt)
  );

  mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .ICNT_W(16), .ILLEGAL_HALT(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero), .Mem_Ready(mem_ready),
    .PC_En(b_pc_en), .I_or_D(b_i_or_d), .Mem_Write(b_mem_write), .IR_Write(b_ir_write),
    .Reg_Dst(b_reg_dst), .Mem_to_Reg(b_mem_to_reg), .Reg_Write(b_reg_write),
    .ALU_Src_A(b_src_a), .ALU_Src_B(b_src_b), .ALU_Control(b_alu), .PC_Src(b_pc_src),
    .Illegal_Op(b_ill), .Instr_Count(b_cnt)
  );

  // Instance 0 uses the handshake, halts on illegal and has a 2-bit counter. Instance 1 does none of these.
  function automatic bit inst_hs(int i);
    return (i == 0);
  endfunction

  function automatic bit inst_halt(int i);
    return (i == 0);
  endfunction

  function automatic int inst_w(int i);
    return (i == 0) ? 2 : 16;
  endfunction

  function automatic int decode_class(logic [5:0] o);
    case (o)
      OP_R:            return C_R;
      OP_LW, OP_SW:    return C_MEM;
      OP_BEQ, OP_BNE:  return C_BR;
      OP_J:            return C_J;
      OP_ADDI:         return C_I;
      OP_ANDI, OP_ORI: return C_IZ;
      default:         return -1;
    endcase
  endfunction

  function automatic int r_alu(logic [5:0] f);
    case (f)
      FN_ADD:  return 2;
      FN_SUB:  return 6;
      FN_AND:  return 0;
      FN_OR:   return 1;
      FN_SLT:  return 7;
      default: return -1;
    endcase
  endfunction

  function automatic ctrl_t expect_ctrl(int i);
    ctrl_t c;
    bit rdy;
    c = '0;
    c.alu = 3'b010;
    rdy = inst_hs(i) ? mem_ready : 1'b1;
    case (m_step[i])
      S_FETCH: begin c.src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
      S_DEC:   c.src_b = 2'b10;
      S_EXEC: begin
        case (m_cls[i])
          C_R:  begin c.src_a = 1'b1; if (r_alu(funct) >= 0) c.alu = 3'(r_alu(funct)); end
          C_MEM, C_I: begin c.src_a = 1'b1; c.src_b = 2'b10; end
          C_IZ: begin c.src_a = 1'b1; c.src_b = 2'b11; c.alu = (op == OP_ORI) ? 3'b001 : 3'b000; end
          C_BR: begin
            c.src_a = 1'b1; c.alu = 3'b110; c.pc_src = 2'b01;
            c.pc_en = zero ^ (op == OP_BNE);
          end
          default: begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
        endcase
      end
      S_WB: begin
        if (m_cls[i] == C_MEM) begin
          c.i_or_d = 1'b1; c.mem_write = m_store[i];
        end else begin
          c.reg_write = 1'b1; c.reg_dst = (m_cls[i] == C_R);
        end
      end
      S_MWB: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      c.pc_en = 1'b0; c.mem_write = 1'b0; c.ir_write = 1'b0; c.reg_write = 1'b0;
    end
    return c;
  endfunction

  task automatic retire_model(int i);
    m_cnt[i]  = (m_cnt[i] + 1) % (32'd1 << inst_w(i));
    m_step[i] = S_FETCH;
  endtask

  task automatic model_update(int i);
    bit rdy;
    rdy = inst_hs(i) ? mem_ready : 1'b1;
    if (reset) begin
      m_step[i] = S_FETCH; m_ill[i] = 1'b0; m_cnt[i] = 0;
      return;
    end
    case (m_step[i])
      S_FETCH: if (rdy) m_step[i] = S_DEC;
      S_DEC: begin
        if (decode_class(op) < 0) m_step[i] = S_ILL;
        else begin m_cls[i] = decode_class(op); m_step[i] = S_EXEC; end
      end
      S_EXEC: begin
        case (m_cls[i])
          C_R:         m_step[i] = (r_alu(funct) < 0) ? S_ILL : S_WB;
          C_MEM:       begin m_store[i] = (op == OP_SW); m_step[i] = S_WB; end
          C_BR, C_J:   retire_model(i);
          default:     m_step[i] = S_WB;
        endcase
      end
      S_WB: begin
        if (m_cls[i] != C_MEM) retire_model(i);
        else if (rdy && m_store[i]) retire_model(i);
        else if (rdy) m_step[i] = S_MWB;
      end
      S_MWB: retire_model(i);
      S_ILL: begin m_ill[i] = 1'b1; m_step[i] = inst_halt(i) ? S_HALT : S_FETCH; end
      default: ;
    endcase
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Every-cycle compare against the model, then advance the model past the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (i == 0)
        act_w = {a_pc_en, a_i_or_d, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                 a_reg_write, a_src_a, a_src_b, a_alu, a_pc_src};
      else
        act_w = {b_pc_en, b_i_or_d, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                 b_reg_write, b_src_a, b_src_b, b_alu, b_pc_src};
      exp_w = expect_ctrl(i);
      check_output((i == 0) ? "a_ctrl_word" : "b_ctrl_word", 32'(act_w), 32'(exp_w));
      check_output((i == 0) ? "a_illegal_op" : "b_illegal_op",
                   32'((i == 0) ? a_ill : b_ill), 32'(m_ill[i]));
      check_output((i == 0) ? "a_instr_count" : "b_instr_count",
                   (i == 0) ? 32'(a_cnt) : 32'(b_cnt), m_cnt[i]);
    end
    for (int i = 0; i < 2; i++) model_update(i);
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_stimulus(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    op = o; funct = f; zero = z; mem_ready = r;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
    apply_stimulus(o, f, z, 1'b1);
    repeat (n) step_cycle();
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(OP_R, FN_ADD, 1'b0, 1'b1);
    step_cycle(); settle();
    check_output("rst_pc_en", 32'(a_pc_en), 0);
    check_output("rst_ir_write", 32'(a_ir_write), 0);
    check_output("rst_count", 32'(a_cnt), 0);
    step_cycle(); reset = 1'b0; settle();
    check_output("fetch_ir_write", 32'(a_ir_write), 1);
    check_output("fetch_pc_en", 32'(a_pc_en), 1);
    check_output("fetch_src_b", 32'(a_src_b), 1);
    step_cycle(); settle();
    check_output("decode_src_b", 32'(a_src_b), 2);
    step_cycle(); settle();
    check_output("exec_r_src_a", 32'(a_src_a), 1);
    check_output("exec_r_alu_add", 32'(a_alu), 2);
    step_cycle(); apply_stimulus(OP_LW, FN_ADD, 1'b0, 1'b1); settle();
    check_output("wb_r_reg_write", 32'(a_reg_write), 1);
    check_output("wb_r_reg_dst", 32'(a_reg_dst), 1);
    step_cycle(); settle();
    check_output("r_count", 32'(a_cnt), 1);

    // lw with three stalled MEM_RD cycles before memory answers.
    step_cycle(); step_cycle();
    step_cycle(); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step_cycle();
      if (i == 3) mem_ready = 1'b1;
      settle();
      check_output("lw_stall_i_or_d", 32'(a_i_or_d), 1);
    end
    step_cycle(); apply_stimulus(OP_BEQ, FN_ADD, 1'b1, 1'b1); settle();
    check_output("mem_wb_mem_to_reg", 32'(a_mem_to_reg), 1);
    check_output("mem_wb_reg_write", 32'(a_reg_write), 1);
    step_cycle(); settle();
    check_output("lw_count", 32'(a_cnt), 2);

    step_cycle(); step_cycle(); settle();
    check_output("beq_pc_en", 32'(a_pc_en), 1);
    check_output("beq_pc_src", 32'(a_pc_src), 1);
    step_cycle(); apply_stimulus(OP_BNE, FN_ADD, 1'b1, 1'b1); settle();
    check_output("beq_count", 32'(a_cnt), 3);
    step_cycle(); step_cycle(); settle();
    check_output("bne_pc_en", 32'(a_pc_en), 0);
    check_output("bne_pc_src", 32'(a_pc_src), 1);
    // Fourth retirement wraps the 2-bit counter.
    step_cycle(); apply_stimulus(OP_ORI, FN_ADD, 1'b0, 1'b1); settle();
    check_output("bne_count_wrap", 32'(a_cnt), 0);

    step_cycle(); step_cycle(); settle();
    check_output("ori_src_b", 32'(a_src_b), 3);
    check_output("ori_alu", 32'(a_alu), 1);
    step_cycle(); settle();
    check_output("wb_i_reg_write", 32'(a_reg_write), 1);
    check_output("wb_i_reg_dst", 32'(a_reg_dst), 0);
    step_cycle(); apply_stimulus(OP_BAD, FN_ADD, 1'b0, 1'b1); settle();
    check_output("ori_count", 32'(a_cnt), 1);

    step_cycle(); step_cycle(); settle();
    check_output("illegal_cycle_flag", 32'(a_ill), 0);
    for (int i = 0; i < 10; i++) begin
      step_cycle(); settle();
      check_output("halt_flag", 32'(a_ill), 1);
      check_output("halt_enables", 32'(a_pc_en | a_ir_write | a_reg_write | a_mem_write), 0);
      check_output("halt_count", 32'(a_cnt), 1);
    end
    reset = 1'b1; apply_stimulus(OP_SW, FN_ADD, 1'b0, 1'b1);
    step_cycle(); reset = 1'b0; settle();
    check_output("rst_clears_flag", 32'(a_ill), 0);
    check_output("rst_clears_count", 32'(a_cnt), 0);
    check_output("restart_fetch", 32'(a_ir_write), 1);

    // sw stalled in MEM_WR, then reset lands while the write is pending.
    step_cycle(); step_cycle(); mem_ready = 1'b0;
    step_cycle(); settle();
    check_output("sw_mem_write", 32'(a_mem_write), 1);
    check_output("sw_i_or_d", 32'(a_i_or_d), 1);
    step_cycle(); reset = 1'b1; settle();
    check_output("rst_mem_write", 32'(a_mem_write), 0);
    step_cycle(); reset = 1'b0; settle();
    check_output("sw_abandoned_count", 32'(a_cnt), 0);
    check_output("stalled_fetch_ir", 32'(a_ir_write), 0);
    check_output("stalled_fetch_pc", 32'(a_pc_en), 0);

    // Five jumps: 5 mod 4 = 1.
    apply_stimulus(OP_J, FN_ADD, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step_cycle(); settle();
      if (i == 2) begin
        check_output("jump_pc_en", 32'(a_pc_en), 1);
        check_output("jump_pc_src", 32'(a_pc_src), 2);
      end
    end
    check_output("jump_wrap_count", 32'(a_cnt), 1);

    run_instr(OP_R, FN_SUB, 1'b0, 4);
    run_instr(OP_R, FN_AND, 1'b0, 4);
    run_instr(OP_R, FN_OR, 1'b0, 4);
    run_instr(OP_R, FN_SLT, 1'b0, 4);
    run_instr(OP_ADDI, FN_ADD, 1'b0, 4);
    run_instr(OP_ANDI, FN_ADD, 1'b0, 4);
    run_instr(OP_SW, FN_ADD, 1'b0, 4);
    run_instr(OP_BEQ, FN_ADD, 1'b0, 3);
    run_instr(OP_BNE, FN_ADD, 1'b0, 3);
    run_instr(OP_LW, FN_ADD, 1'b0, 5);
    settle();
    check_output("sweep_count", 32'(a_cnt), 3);

    apply_stimulus(OP_R, 6'b000111, 1'b0, 1'b1);
    repeat (3) step_cycle();
    settle();
    check_output("bad_funct_pending", 32'(a_ill), 0);
    step_cycle(); settle();
    check_output("bad_funct_flag", 32'(a_ill), 1);
    check_output("bad_funct_count", 32'(a_cnt), 3);
    repeat (3) step_cycle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
